// File: rtl/seq_pkg.sv
// Shared definitions for the 9-bit-instruction datapath.
// The sequencer, control decoder and assembler all use these.
//   state_t    : sequencer FSM states
//   HALT_INSTR : opcode that ends a run (it is never latched into ir)
//   NOP_INSTR  : value ir holds after reset
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EXEC    = 3'd2,
        MEMWAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;
    localparam logic [8:0] NOP_INSTR  = 9'h1FE;

    // True in the states that count toward cycle_count.
    function automatic logic is_busy(input state_t s);
        return (s == FETCH) || (s == EXEC) || (s == MEMWAIT);
    endfunction

endpackage

// File: rtl/exec_sequencer_prog_ctr.sv
// Program counter for the exec sequencer.
//   clk, reset_n  : clock, asynchronous active-low reset (pc -> 0)
//   clear         : load 0; a new run is starting
//   advance       : the current instruction retires; load the next pc
//   branch_taken  : take target instead of pc+1 when advancing
//   target        : branch target address
//   pc            : instruction ROM address
// pc+1 wraps from the top of the ROM to 0 because it is truncated to PC_W bits.
module prog_ctr #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            advance,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;

    always_comb begin
        pc_next = pc_reg;
        if (clear) begin
            pc_next = '0;
        end else if (advance) begin
            pc_next = branch_taken ? target : pc_reg + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer: owns the pc, fetches from the instruction ROM, latches
// the instruction for the decoder, qualifies writes and stalls for memory ops.
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : level; in IDLE or DONE it begins a run at pc 0
//   instr         : ROM data at pc (combinational ROM)
//   branch_taken  : decoder branch decision for ir
//   target        : branch target for ir
//   mem_op        : ir is a load or a store
//   pc            : instruction ROM address
//   ir            : latched instruction feeding the decoder
//   exec_en       : one-cycle write qualifier, once per retired instruction
//   busy          : high in FETCH/EXEC/MEMWAIT
//   done          : high in DONE
//   cycle_count   : busy cycles in the current/last run, saturating
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    target,
    input  logic               mem_op,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_en,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam logic [INSTR_W-1:0] HALT_W = INSTR_W'(HALT_INSTR);
    localparam logic [INSTR_W-1:0] NOP_W  = INSTR_W'(NOP_INSTR);
    // MEMWAIT lasts MEM_LAT cycles: the counter is loaded with MEM_LAT-1 and
    // the write fires in the cycle it reads zero.
    localparam logic [2:0] WAIT_INIT = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;
    localparam logic       NO_STALL  = (MEM_LAT == 0);

    state_t             state_reg;
    logic [2:0]         wait_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [CNT_W-1:0]   cycle_reg;
    logic               start_run;

    assign start_run = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_comb begin
        exec_en = 1'b0;
        case (state_reg)
            EXEC:    exec_en = !mem_op || NO_STALL;
            MEMWAIT: exec_en = (wait_reg == 3'd0);
            default: exec_en = 1'b0;
        endcase
    end

    prog_ctr #(
        .PC_W(PC_W)
    ) u_prog_ctr (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (start_run),
        .advance      (exec_en),
        .branch_taken (branch_taken),
        .target       (target),
        .pc           (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            wait_reg  <= 3'd0;
            ir_reg    <= NOP_W;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cycle_reg <= '0;
        end else begin
            // Counting is driven by the current state so the cycle that
            // fetches HALT is included in the total.
            if (start_run) begin
                cycle_reg <= '0;
            end else if (is_busy(state_reg) && !(&cycle_reg)) begin
                cycle_reg <= cycle_reg + CNT_W'(1);
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= FETCH;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (instr == HALT_W) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        ir_reg    <= instr;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_en) begin
                        state_reg <= FETCH;
                    end else begin
                        wait_reg  <= WAIT_INIT;
                        state_reg <= MEMWAIT;
                    end
                end
                MEMWAIT: begin
                    if (wait_reg != 3'd0) begin
                        wait_reg <= wait_reg - 3'd1;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ir          = ir_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign cycle_count = cycle_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;
    import seq_pkg::*;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 10;
    localparam int DEPTH   = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ASZ     = 2100;

    localparam logic [8:0] ADD_A = 9'h011;
    localparam logic [8:0] ADD_B = 9'h022;
    localparam logic [8:0] LW_I  = 9'h141;
    localparam logic [8:0] SW_I  = 9'h142;
    localparam logic [8:0] BR7   = 9'h187;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic               branch_taken;
    logic [PC_W-1:0]    target;
    logic               mem_op;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               exec_en;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   cycle_count;

    // Program ROM and a toy decoder: [8:6]=101 load/store, 110 branch via LUT.
    logic [8:0]      rom     [DEPTH];
    logic [PC_W-1:0] tgt_lut [64];

    assign instr        = rom[pc];
    assign mem_op       = (ir[8:6] == 3'b101);
    assign branch_taken = (ir[8:6] == 3'b110);
    assign target       = tgt_lut[ir[5:0]];

    exec_sequencer #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .branch_taken(branch_taken), .target(target), .mem_op(mem_op),
        .pc(pc), .ir(ir), .exec_en(exec_en), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction-level reference: per busy cycle k, expected pc/ir/exec_en.
    int         e_pc [ASZ];
    bit         e_en [ASZ];
    logic [8:0] e_ir [ASZ];
    int         m_T;
    bit         m_halt;
    int         m_pcf;
    int         m_nexec;
    logic [8:0] m_irf;
    logic [8:0] m_ir_state = NOP_INSTR;

    typedef struct {
        string      name;
        int         n_pre;
        logic [8:0] ins;
        int         exp_pc;
        int         exp_cc;
        logic [8:0] exp_ir;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fill_halt();
        for (int i = 0; i < DEPTH; i++) rom[i] = HALT_INSTR;
    endtask

    task automatic model_build(input int maxc);
        int p, b, lat;
        logic [8:0] i, irv;
        p = 0; b = 0; irv = m_ir_state; m_halt = 0; m_pcf = 0; m_nexec = 0;
        while (b < maxc) begin
            i = rom[p];
            b++; e_pc[b] = p; e_en[b] = 1'b0; e_ir[b] = irv;   // fetch cycle
            if (i == HALT_INSTR) begin
                m_halt = 1; m_pcf = p;
                break;
            end
            irv = i;
            lat = (i[8:6] == 3'b101) ? 2 + MEM_LAT : 2;
            for (int c = 1; c < lat; c++) begin
                b++; e_pc[b] = p; e_en[b] = (c == lat - 1); e_ir[b] = irv;
            end
            m_nexec++;
            p = (i[8:6] == 3'b110) ? int'(tgt_lut[i[5:0]]) : (p + 1) % DEPTH;
        end
        m_T = m_halt ? b : maxc;
        m_irf = irv;
    endtask

    // Starts a run from IDLE/DONE (sim time = posedge+1) and checks every busy
    // cycle; if the program halts, also checks the DONE state.
    task automatic run_prog(input string nm, input int maxc);
        int nexec, cc_exp;
        model_build(maxc);
        nexec = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= m_T; k++) begin
            start = (m_halt && k >= m_T) ? 1'b0 : 1'($urandom % 2);
            cc_exp = (k - 1 > CNT_MAX) ? CNT_MAX : k - 1;
            if (exec_en) nexec++;
            chk("busy", 32'(busy), 32'd1);
            chk("done_low", 32'(done), 32'd0);
            chk("exec_en", 32'(exec_en), 32'(e_en[k]));
            chk("pc", 32'(pc), 32'(e_pc[k]));
            chk("ir", 32'(ir), 32'(e_ir[k]));
            chk("cycle_count", 32'(cycle_count), 32'(cc_exp));
            if (k < m_T || m_halt) begin
                @(posedge clk); #1;
            end
        end
        if (m_halt) begin
            cc_exp = (m_T > CNT_MAX) ? CNT_MAX : m_T;
            chk("done", 32'(done), 32'd1);
            chk("busy_done", 32'(busy), 32'd0);
            chk("exec_en_done", 32'(exec_en), 32'd0);
            chk("pc_done", 32'(pc), 32'(m_pcf));
            chk("ir_done", 32'(ir), 32'(m_irf));
            chk("cc_done", 32'(cycle_count), 32'(cc_exp));
            chk("exec_count", 32'(nexec), 32'(m_nexec));
            m_ir_state = m_irf;
            @(posedge clk); #1;
            chk("done_hold", 32'(done), 32'd1);
            chk("pc_hold", 32'(pc), 32'(m_pcf));
            chk("cc_hold", 32'(cycle_count), 32'(cc_exp));
        end
        $display("run %s: cycles=%0d execs=%0d halted=%0d pc=%0h cc=%0d",
                 nm, m_T, nexec, m_halt, pc, cycle_count);
    endtask

    initial begin
        tbl[0] = '{"add_add_halt", 1, ADD_B,      2,    5,  ADD_B};
        tbl[1] = '{"halt_first",   0, HALT_INSTR, 0,    1,  ADD_B};
        tbl[2] = '{"lw_at0",       0, LW_I,       1,    6,  LW_I};
        tbl[3] = '{"sw_at2",       2, SW_I,       3,    10, SW_I};
        tbl[4] = '{"br_at5",       5, BR7,        'h37, 13, BR7};
        tbl[5] = '{"add_at5",      5, ADD_B,      6,    13, ADD_B};

        for (int i = 0; i < 64; i++) tgt_lut[i] = '0;
        tgt_lut[7] = 10'h037;
        tgt_lut[9] = 10'h3FF;
        fill_halt();

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir), 32'(NOP_INSTR));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_exec_en", 32'(exec_en), 32'd0);
        chk("rst_cc", 32'(cycle_count), 32'd0);
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed single-instruction table; runs chain DONE -> FETCH.
        for (int t = 0; t < 6; t++) begin
            fill_halt();
            for (int i = 0; i < tbl[t].n_pre; i++) rom[i] = ADD_A;
            rom[tbl[t].n_pre] = tbl[t].ins;
            run_prog(tbl[t].name, 200);
            chk({tbl[t].name, "_pc"}, 32'(pc), 32'(tbl[t].exp_pc));
            chk({tbl[t].name, "_cc"}, 32'(cycle_count), 32'(tbl[t].exp_cc));
            chk({tbl[t].name, "_ir"}, 32'(ir), 32'(tbl[t].exp_ir));
        end

        // Long straight-line run: cycle_count saturates.
        fill_halt();
        for (int i = 0; i < 512; i++) rom[i] = ADD_A;
        run_prog("saturate", 1100);
        chk("sat_cc", 32'(cycle_count), 32'(CNT_MAX));

        // Random programs.
        for (int r = 0; r < 15; r++) begin
            int n;
            m_halt = 0;
            for (int a = 0; a < 60 && !m_halt; a++) begin
                fill_halt();
                n = $urandom_range(4, 30);
                for (int i = 0; i < n; i++) begin
                    case ($urandom % 5)
                        0: rom[i] = {3'b000, 6'($urandom)};
                        1: rom[i] = {3'b101, 6'($urandom)};
                        2: rom[i] = {3'b110, 6'($urandom)};
                        3: rom[i] = {3'b011, 6'($urandom)};
                        default: rom[i] = NOP_INSTR;
                    endcase
                end
                for (int i = 0; i < 64; i++) tgt_lut[i] = PC_W'($urandom_range(0, n + 3));
                model_build(1500);
            end
            if (m_halt) run_prog("random", 1500);
        end

        // Wrap 3FF -> 0 (loops forever), then reset asynchronously mid-EXEC.
        fill_halt();
        tgt_lut[9] = 10'h3FF;
        rom[0] = ADD_A;
        rom[1] = {3'b110, 6'd9};
        rom[10'h3FF] = ADD_B;
        run_prog("wrap", 10);
        start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_ir", 32'(ir), 32'(NOP_INSTR));
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_exec_en", 32'(exec_en), 32'd0);
        chk("arst_cc", 32'(cycle_count), 32'd0);
        m_ir_state = NOP_INSTR;
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Fresh run from IDLE after the reset.
        fill_halt();
        rom[0] = ADD_A;
        rom[1] = ADD_B;
        run_prog("post_reset", 200);
        chk("post_reset_cc", 32'(cycle_count), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
